// File: rtl/fft_frame_buffer_if.sv
// Sample stream from a frame buffer lane to its FFT core.
// The master drives data, valid and last; the slave drives ready.
interface fft_frame_buffer_if #(
    parameter int DATA_WIDTH = 12
);
    logic signed [DATA_WIDTH-1:0] fft_data;
    logic                         fft_valid;
    logic                         fft_ready;
    logic                         fft_last;

    modport master (output fft_data, output fft_valid, output fft_last, input fft_ready);
    modport slave  (input fft_data, input fft_valid, input fft_last, output fft_ready);
endinterface

// File: rtl/fft_frame_buffer.sv
// Per-lane FFT input frame buffer: captures one frame of offset-binary ADC codes,
// stores them as two's complement and streams the frame out over valid/ready.
module fft_frame_buffer #(
    parameter int DATA_WIDTH  = 12,
    parameter int FRAME_LEN   = 1024,
    parameter int ADDR_WIDTH  = 10,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   write_active,
    input  logic [DATA_WIDTH-1:0]  sample_in,
    input  logic                   flush,
    fft_frame_buffer_if.master     fft,
    output logic                   filling,
    output logic                   overrun,
    output logic [COUNT_WIDTH-1:0] frame_count
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_LEN - 1);

    typedef enum logic {FILL, STREAM} state_t;

    state_t                       state_q, state_d;
    logic [ADDR_WIDTH-1:0]        write_ptr, read_ptr;
    logic                         rd_done;
    logic                         wr_en, rd_en, last_hs, drop;
    logic signed [DATA_WIDTH-1:0] mem [FRAME_LEN];
    logic signed [DATA_WIDTH-1:0] data_p0;
    logic                         vld_p0, last_p0;

    // Offset-binary to two's complement is a plain MSB flip; the range maps exactly.
    function automatic logic signed [DATA_WIDTH-1:0] to_twos(input logic [DATA_WIDTH-1:0] code);
        return signed'({~code[DATA_WIDTH-1], code[DATA_WIDTH-2:0]});
    endfunction

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        drop    = 1'b0;
        last_hs = vld_p0 && last_p0 && fft.fft_ready;
        case (state_q)
            FILL: begin
                wr_en = write_active;
                if (write_active && write_ptr == LAST_ADDR)
                    state_d = STREAM;
            end
            STREAM: begin
                drop  = write_active;
                // The read register only advances when its word is empty or taken,
                // so it doubles as the stall-stable output stage.
                rd_en = !rd_done && (!vld_p0 || fft.fft_ready);
                if (last_hs)
                    state_d = FILL;
            end
            default: state_d = FILL;
        endcase
        if (flush) begin
            state_d = FILL;
            wr_en   = 1'b0;
            rd_en   = 1'b0;
            drop    = 1'b0;
            last_hs = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[write_ptr] <= to_twos(sample_in);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FILL;
            write_ptr   <= '0;
            read_ptr    <= '0;
            rd_done     <= 1'b0;
            data_p0     <= '0;
            vld_p0      <= 1'b0;
            last_p0     <= 1'b0;
            overrun     <= 1'b0;
            frame_count <= '0;
        end else begin
            state_q <= state_d;
            if (drop)
                overrun <= 1'b1;
            if (last_hs)
                frame_count <= frame_count + 1'b1;
            if (flush) begin
                write_ptr <= '0;
                read_ptr  <= '0;
                rd_done   <= 1'b0;
                vld_p0    <= 1'b0;
                last_p0   <= 1'b0;
            end else begin
                if (wr_en)
                    write_ptr <= (write_ptr == LAST_ADDR) ? '0 : write_ptr + 1'b1;
                // ---- stage p0: synchronous RAM read, presented directly to the FFT ----
                if (rd_en) begin
                    data_p0  <= mem[read_ptr];
                    last_p0  <= (read_ptr == LAST_ADDR);
                    vld_p0   <= 1'b1;
                    read_ptr <= (read_ptr == LAST_ADDR) ? '0 : read_ptr + 1'b1;
                    if (read_ptr == LAST_ADDR)
                        rd_done <= 1'b1;
                end else if (fft.fft_ready) begin
                    vld_p0 <= 1'b0;
                end
                if (last_hs) begin
                    last_p0 <= 1'b0;
                    rd_done <= 1'b0;
                end
            end
        end
    end

    assign fft.fft_data  = data_p0;
    assign fft.fft_valid = vld_p0;
    assign fft.fft_last  = last_p0;
    assign filling       = (state_q == FILL);

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Scoreboard bench for fft_frame_buffer: expected stream words are queued as frames
// are written and compared on every valid/ready handshake.
module tb_fft_frame_buffer;

    localparam int DW = 12;
    localparam int FL = 1024;
    localparam int AW = 10;
    localparam int CW = 3;   // narrow counter so the wrap is reached in few frames

    logic          clk = 1'b0;
    logic          reset;
    logic          write_active;
    logic [DW-1:0] sample_in;
    logic          flush;
    logic          filling;
    logic          overrun;
    logic [CW-1:0] frame_count;

    always #5 clk = ~clk;

    fft_frame_buffer_if #(.DATA_WIDTH(DW)) fft ();

    fft_frame_buffer #(
        .DATA_WIDTH(DW), .FRAME_LEN(FL), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .write_active(write_active),
        .sample_in(sample_in),
        .flush(flush),
        .fft(fft),
        .filling(filling),
        .overrun(overrun),
        .frame_count(frame_count)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            checks    = 0;
    int            failures  = 0;
    int            hs_count  = 0;
    int            rdy_mode  = 0;
    int            rdy_cnt   = 0;
    logic [CW-1:0] exp_fc;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Handshakes are sampled on the falling edge, half a cycle before the DUT takes them.
    always @(negedge clk) begin
        if (reset && fft.fft_valid && fft.fft_ready) begin
            hs_count++;
            if (sb.size() == 0) begin
                check("unexpected_beat", 32'(sb.size()), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                check("data", 32'($unsigned(fft.fft_data)), 32'(mon_e.data));
                check("last", 32'(fft.fft_last), 32'(mon_e.last));
            end
        end
    end

    // Ready modes: 0 always, 1 the pattern 1,0,0,1 repeating, 2 never.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       fft.fft_ready = 1'b1;
            1:       fft.fft_ready = (rdy_cnt % 4 == 0) || (rdy_cnt % 4 == 3);
            default: fft.fft_ready = 1'b0;
        endcase
        rdy_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    function automatic logic [DW-1:0] pat(input int kind, input int i);
        case (kind)
            0:       return DW'(i);
            1:       return 12'hFFF;
            2:       return DW'(i * 7 + 5);
            default: return DW'(i + kind * 13);
        endcase
    endfunction

    task automatic write_samples(input int kind, input int n, input int gap, input bit push);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            write_active = 1'b1;
            sample_in    = pat(kind, i);
            if (push) begin
                e.data = pat(kind, i) ^ 12'h800;
                e.last = (i == FL - 1);
                sb.push_back(e);
            end
            step();
            write_active = 1'b0;
            if (gap > 1) idle(gap - 1);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || fft.fft_valid) && n < budget) begin
            step();
            n++;
        end
        check("drain_left", 32'(sb.size()), 32'd0);
        check("frame_count", 32'(frame_count), 32'(exp_fc));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        int n;
        reset        = 1'b0;
        write_active = 1'b0;
        sample_in    = '0;
        flush        = 1'b0;
        exp_fc       = '0;
        idle(3);
        check("rst_valid", 32'(fft.fft_valid), 32'd0);
        check("rst_last", 32'(fft.fft_last), 32'd0);
        check("rst_data", 32'($unsigned(fft.fft_data)), 32'd0);
        check("rst_filling", 32'(filling), 32'd1);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_fc", 32'(frame_count), 32'd0);
        reset = 1'b1;
        idle(2);

        // Index ramp, continuous ready, latency of the first word.
        rdy_mode = 0;
        write_samples(0, FL, 1, 1);
        check("lat_n1_valid", 32'(fft.fft_valid), 32'd0);
        step();
        check("lat_n2_valid", 32'(fft.fft_valid), 32'd1);
        check("lat_n2_data", 32'($unsigned(fft.fft_data)), 32'h800);
        exp_fc = exp_fc + 1'b1;
        wait_drain(3000);

        // Same frame with ready toggling.
        rdy_mode = 1;
        write_samples(0, FL, 1, 1);
        exp_fc = exp_fc + 1'b1;
        wait_drain(6000);
        rdy_mode = 0;
        idle(2);

        // Flush while a stalled frame is streaming, then flush a partial fill.
        rdy_mode = 2;
        idle(1);
        write_samples(2, FL, 1, 0);
        idle(4);
        check("stall_valid", 32'(fft.fft_valid), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_valid", 32'(fft.fft_valid), 32'd0);
        check("flush_last", 32'(fft.fft_last), 32'd0);
        check("flush_filling", 32'(filling), 32'd1);
        check("flush_fc", 32'(frame_count), 32'(exp_fc));
        rdy_mode = 0;
        idle(2);
        write_samples(2, 500, 1, 0);
        flush        = 1'b1;
        write_active = 1'b1;
        sample_in    = 12'hABC;
        step();
        flush        = 1'b0;
        write_active = 1'b0;
        check("flush2_filling", 32'(filling), 32'd1);
        check("flush2_overrun", 32'(overrun), 32'd0);
        write_samples(1, FL, 1, 1);
        exp_fc = exp_fc + 1'b1;
        wait_drain(3000);
        check("flush_overrun_end", 32'(overrun), 32'd0);

        // Overrun while the FFT core stalls; the held frame must survive intact.
        rdy_mode = 2;
        write_samples(2, FL, 1, 1);
        idle(3);
        repeat (3) begin
            write_active = 1'b1;
            sample_in    = 12'h123;
            step();
            write_active = 1'b0;
            step();
        end
        check("overrun_set", 32'(overrun), 32'd1);
        check("stream_filling", 32'(filling), 32'd0);
        rdy_mode = 0;
        exp_fc = exp_fc + 1'b1;
        wait_drain(3000);
        write_samples(0, FL, 1, 1);
        exp_fc = exp_fc + 1'b1;
        wait_drain(3000);

        // Asynchronous reset at sample 300 of a stream.
        base = hs_count;
        write_samples(0, FL, 1, 1);
        n = 0;
        while (hs_count < base + 300 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("reach_300", 32'(hs_count >= base + 300), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", 32'(fft.fft_valid), 32'd0);
        check("arst_last", 32'(fft.fft_last), 32'd0);
        check("arst_data", 32'($unsigned(fft.fft_data)), 32'd0);
        check("arst_fc", 32'(frame_count), 32'd0);
        check("arst_filling", 32'(filling), 32'd1);
        check("arst_overrun", 32'(overrun), 32'd0);
        sb.delete();
        exp_fc = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(1);
        write_samples(3, FL, 1, 1);
        exp_fc = exp_fc + 1'b1;
        wait_drain(3000);

        // Gapped frames from a fresh reset until the counter wraps.
        reset = 1'b0;
        step();
        reset = 1'b1;
        exp_fc = '0;
        idle(1);
        for (int f = 0; f < (1 << CW); f++) begin
            write_samples(4 + f, FL, 4, 1);
            exp_fc = exp_fc + 1'b1;
            wait_drain(3000);
        end
        check("fc_wrap", 32'(frame_count), 32'd0);
        check("gapped_overrun", 32'(overrun), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
